// File: rtl/rvv_alu_seq.sv
// rvv_alu_seq: element/slice sequencer driving rvv_alu and collecting its lane results into a destination image
module rvv_alu_seq #(
   parameter int VLEN       = 128,
   parameter int LANE_WIDTH = 3
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            start,
   input  logic            kill,
   input  logic [16:0]     vl,
   input  logic [2:0]      vsew,
   input  logic            vm,
   input  logic [VLEN-1:0] v0_mask,
   input  logic [VLEN-1:0] vd_old,
   input  logic            alu_instr_valid,
   input  logic [63:0]     alu_vd,
   input  logic [16:0]     alu_index,
   output logic            alu_run,
   output logic [16:0]     alu_byte_i,
   output logic [3:0]      alu_in_reg_offset,
   output logic [2:0]      alu_vsew,
   output logic            busy,
   output logic            done,
   output logic            vd_we,
   output logic [VLEN-1:0] vd_out,
   output logic            illegal
);
   localparam logic [3:0] LW = 4'(LANE_WIDTH);
   localparam int         IW = $clog2(VLEN);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state_q, state_d;
   logic [16:0]     vl_q, vl_d, e_q, e_d;
   logic [3:0]      o_q, o_d;
   logic [2:0]      vsew_q, vsew_d;
   logic            vm_q, vm_d, illegal_q, illegal_d;
   logic [VLEN-1:0] mask_q, mask_d, vd_q, vd_d;

   logic [3:0]      sh, s_m1, wlog;
   logic [63:0]     lmask;
   logic [VLEN-1:0] wmask, wdata;
   logic [16:0]     vmax, vl_c;
   logic            en, last_slice, bad;

   // sh = log2(SEW); slices per element and lane write width follow from it
   assign sh         = 4'(vsew_q) + 4'd3;
   assign s_m1       = (sh >= LW) ? 4'((16'd1 << (sh - LW)) - 16'd1) : 4'd0;
   assign wlog       = (sh < LW) ? sh : LW;
   assign lmask      = (wlog >= 4'd6) ? '1 : (64'd1 << (7'd1 << wlog)) - 64'd1;
   assign wmask      = VLEN'(lmask) << alu_index;
   assign wdata      = VLEN'(alu_vd) << alu_index;
   assign vmax       = 17'(VLEN) >> (4'(vsew) + 4'd3);
   assign vl_c       = (vl > vmax) ? vmax : vl;
   assign bad        = (vsew > 3'd3) || !alu_instr_valid;
   assign en         = vm_q || mask_q[e_q[IW-1:0]];
   assign last_slice = o_q == s_m1;

   assign busy              = state_q != IDLE;
   assign done              = (state_q == DONE) && !kill;
   assign vd_we             = done;
   assign alu_run           = state_q == RUN;
   assign alu_byte_i        = alu_run ? e_q : '0;
   assign alu_in_reg_offset = alu_run ? o_q : '0;
   assign alu_vsew          = vsew_q;
   assign vd_out            = vd_q;
   assign illegal           = illegal_q;

   // next state: accept/reject start, step slices and elements, merge enabled lane results
   always_comb begin
      state_d   = state_q;
      vl_d      = vl_q;
      vsew_d    = vsew_q;
      vm_d      = vm_q;
      mask_d    = mask_q;
      vd_d      = vd_q;
      e_d       = e_q;
      o_d       = o_q;
      illegal_d = 1'b0;
      if (kill) begin
         state_d = IDLE;
         e_d     = '0;
         o_d     = '0;
      end else if (state_q == IDLE) begin
         if (start && bad) illegal_d = 1'b1;
         else if (start) begin
            vl_d    = vl_c;
            vsew_d  = vsew;
            vm_d    = vm;
            mask_d  = v0_mask;
            vd_d    = vd_old;
            e_d     = '0;
            o_d     = '0;
            state_d = (vl_c == '0) ? DONE : RUN;
         end
      end else if (state_q == RUN) begin
         if (en) vd_d = (vd_q & ~wmask) | (wdata & wmask);
         o_d = last_slice ? 4'd0 : o_q + 4'd1;
         e_d = last_slice ? e_q + 17'd1 : e_q;
         if (last_slice && e_q == vl_q - 17'd1) state_d = DONE;
      end else state_d = IDLE;
   end

   // state and datapath registers, cleared asynchronously
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= IDLE;
         vl_q      <= '0;
         vsew_q    <= '0;
         vm_q      <= 1'b0;
         mask_q    <= '0;
         vd_q      <= '0;
         e_q       <= '0;
         o_q       <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         vl_q      <= vl_d;
         vsew_q    <= vsew_d;
         vm_q      <= vm_d;
         mask_q    <= mask_d;
         vd_q      <= vd_d;
         e_q       <= e_d;
         o_q       <= o_d;
         illegal_q <= illegal_d;
      end
   end
endmodule

// File: tb/tb_rvv_alu_seq.sv
// tb_rvv_alu_seq: table-driven and randomized checks of rvv_alu_seq against an element-level model
module tb_rvv_alu_seq;
   localparam int VLEN = 128;

   logic            clk = 1'b0, resetn = 1'b0, start = 1'b0, kill = 1'b0, vm = 1'b1, alu_instr_valid = 1'b1;
   logic [16:0]     vl = '0;
   logic [2:0]      vsew = '0;
   logic [VLEN-1:0] v0_mask = '0, vd_old = '0;
   logic [63:0]     alu_vd;
   logic [16:0]     alu_index;
   logic            alu_run, busy, done, vd_we, illegal;
   logic [16:0]     alu_byte_i;
   logic [3:0]      alu_in_reg_offset;
   logic [2:0]      alu_vsew;
   logic [VLEN-1:0] vd_out;

   rvv_alu_seq #(.VLEN(VLEN), .LANE_WIDTH(3)) dut (
      .clk(clk), .resetn(resetn), .start(start), .kill(kill), .vl(vl), .vsew(vsew), .vm(vm),
      .v0_mask(v0_mask), .vd_old(vd_old), .alu_instr_valid(alu_instr_valid), .alu_vd(alu_vd),
      .alu_index(alu_index), .alu_run(alu_run), .alu_byte_i(alu_byte_i),
      .alu_in_reg_offset(alu_in_reg_offset), .alu_vsew(alu_vsew), .busy(busy), .done(done),
      .vd_we(vd_we), .vd_out(vd_out), .illegal(illegal)
   );

   always #5 clk = ~clk;

   int              total = 0, bad = 0;
   int              cur_op = 0;
   logic [63:0]     cur_a = '0, cur_b = '0;
   logic [VLEN-1:0] last_exp = '0;

   typedef struct {
      int              vl;
      int              sc;
      logic            vm;
      logic [15:0]     m;
      logic [VLEN-1:0] old;
      int              op;
      logic [63:0]     a;
      logic [63:0]     b;
      int              cyc;
   } vec_t;
   vec_t tv[8];

   function automatic logic [63:0] smask(input int sew);
      return (sew == 64) ? '1 : (64'd1 << sew) - 64'd1;
   endfunction

   // whole-element operation: vs2[e] = a + e, vs1[e] = b; op 0 add, 1 and, 2 or
   function automatic logic [63:0] elem(input int e, input int sew, input int op, input logic [63:0] a, input logic [63:0] b);
      logic [63:0] x, y;
      x = (a + 64'(e)) & smask(sew);
      y = b & smask(sew);
      return (op == 0 ? x + y : op == 1 ? x & y : x | y) & smask(sew);
   endfunction

   // ALU stand-in: byte lane o of element e lands at bit e*SEW + 8*o
   always_comb begin
      int sew;
      sew       = 8 << alu_vsew;
      alu_index = 17'(int'(alu_byte_i) * sew + int'(alu_in_reg_offset) * 8);
      alu_vd    = elem(int'(alu_byte_i), sew, cur_op, cur_a, cur_b) >> (int'(alu_in_reg_offset) * 8);
   end

   function automatic logic [VLEN-1:0] model(input int vl_, input int sc, input logic vm_, input logic [VLEN-1:0] m,
                                             input logic [VLEN-1:0] old, input int op, input logic [63:0] a, input logic [63:0] b);
      logic [VLEN-1:0] r;
      logic [63:0]     v;
      int              sew, n;
      sew = 8 << sc;
      n   = (vl_ > VLEN / sew) ? VLEN / sew : vl_;
      r   = old;
      for (int e = 0; e < n; e++) begin
         if (vm_ || m[e]) begin
            v = elem(e, sew, op, a, b);
            for (int k = 0; k < sew; k++) r[e * sew + k] = v[k];
         end
      end
      return r;
   endfunction

   task automatic chk(input string name, input logic [VLEN-1:0] act, input logic [VLEN-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic run_op(input int vl_, input int sc, input logic vm_, input logic [VLEN-1:0] m, input logic [VLEN-1:0] old,
                         input int op, input logic [63:0] a, input logic [63:0] b, input int exp_cyc, input bit restart);
      int n, runs;
      @(negedge clk);
      vl = 17'(vl_); vsew = 3'(sc); vm = vm_; v0_mask = m; vd_old = old;
      cur_op = op; cur_a = a; cur_b = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 1;
      runs = 0;
      while (!done && n < 300) begin
         if (alu_run) runs++;
         start = restart && n == 2;
         if (start) vd_old = ~old;
         @(negedge clk);
         start = 1'b0;
         n++;
      end
      last_exp = model(vl_, sc, vm_, m, old, op, a, b);
      chk("latency", VLEN'(n), VLEN'(exp_cyc));
      chk("run_cycles", VLEN'(runs), VLEN'(exp_cyc - 1));
      chk("vd_we", VLEN'(vd_we), VLEN'(1));
      chk("vd_out", vd_out, last_exp);
      @(negedge clk);
      chk("done_pulse", VLEN'({done, vd_we, busy}), '0);
   endtask

   initial begin
      int sc, mx, vl_, cnt;
      logic [VLEN-1:0] ff;
      ff = '1;
      tv[0] = '{4,  0, 1'b1, 16'h0000, {16{8'h5A}}, 0, 64'd0,          64'd1,    5};
      tv[1] = '{2,  3, 1'b1, 16'h0000, '0,          0, 64'hFFFF_FFFF,  64'd1,    17};
      tv[2] = '{3,  0, 1'b1, 16'h0000, ff,          1, 64'h77,         64'd0,    4};
      tv[3] = '{4,  0, 1'b0, 16'h0005, '0,          2, 64'd0,          64'hAA,   5};
      tv[4] = '{0,  0, 1'b1, 16'h0000, {16{8'h3C}}, 0, 64'd5,          64'd5,    1};
      tv[5] = '{20, 0, 1'b1, 16'h0000, {16{8'hC3}}, 0, 64'd10,         64'd3,    17};
      tv[6] = '{5,  2, 1'b1, 16'h0000, ff,          0, 64'hFFFF_FFF0,  64'h20,   17};
      tv[7] = '{3,  1, 1'b0, 16'h0006, {8{16'h1234}}, 2, 64'h0F00,     64'h00F0, 7};

      repeat (2) @(negedge clk);
      chk("reset_outs", VLEN'({alu_run, alu_byte_i, alu_in_reg_offset, alu_vsew, busy, done, vd_we, illegal}), '0);
      chk("reset_vd", vd_out, '0);
      resetn = 1'b1;

      for (int i = 0; i < 8; i++) begin
         run_op(tv[i].vl, tv[i].sc, tv[i].vm, VLEN'(tv[i].m), tv[i].old, tv[i].op, tv[i].a, tv[i].b, tv[i].cyc, 1'b0);
         if (i == 0) chk("vadd_bytes", VLEN'(vd_out[31:0]), VLEN'(32'h04030201));
         if (i == 1) chk("carry_elem0", VLEN'(vd_out[63:0]), VLEN'(64'h0000_0001_0000_0000));
         if (i == 3) chk("mask_bytes", VLEN'(vd_out[31:0]), VLEN'(32'h00AA00AA));
      end

      @(negedge clk);
      vsew = 3'd4; vl = 17'd4; vd_old = ~last_exp; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("illegal_vsew", VLEN'({illegal, busy}), VLEN'(2'b10));
      chk("illegal_vd_kept", vd_out, last_exp);
      @(negedge clk);
      chk("illegal_one_cycle", VLEN'(illegal), '0);

      vsew = 3'd0; alu_instr_valid = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0; alu_instr_valid = 1'b1;
      chk("illegal_decode", VLEN'({illegal, busy}), VLEN'(2'b10));

      @(negedge clk);
      start = 1'b1; kill = 1'b1;
      @(negedge clk);
      start = 1'b0; kill = 1'b0;
      chk("kill_beats_start", VLEN'({busy, illegal}), '0);
      chk("kill_start_vd", vd_out, last_exp);

      vl = 17'd2; vsew = 3'd3; vm = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      kill = 1'b1;
      @(negedge clk);
      kill = 1'b0;
      chk("kill_idle", VLEN'({busy, done, alu_run}), '0);
      cnt = 0;
      repeat (30) begin
         if (vd_we || busy) cnt++;
         @(negedge clk);
      end
      chk("kill_no_write", VLEN'(cnt), '0);

      vd_old = ff; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      resetn = 1'b0;
      #1;
      chk("async_reset_outs", VLEN'({alu_run, alu_byte_i, alu_in_reg_offset, alu_vsew, busy, done, vd_we, illegal}), '0);
      chk("async_reset_vd", vd_out, '0);
      @(negedge clk);
      resetn = 1'b1;
      cnt = 0;
      repeat (30) begin
         if (vd_we || busy) cnt++;
         @(negedge clk);
      end
      chk("reset_no_write", VLEN'(cnt), '0);

      for (int i = 0; i < 24; i++) begin
         sc  = int'($urandom_range(0, 3));
         mx  = VLEN / (8 << sc);
         vl_ = int'($urandom_range(0, mx + 3));
         run_op(vl_, sc, 1'($urandom), {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                int'($urandom_range(0, 2)), {$urandom, $urandom}, {$urandom, $urandom},
                ((vl_ > mx) ? mx : vl_) * (1 << sc) + 1, (i % 3) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/rvv_alu_seq.md
Name: rvv_alu_seq

Overview:
- Element/slice sequencer and writeback collector that sits directly in front of and behind rvv_alu.
- Per element and per lane-slice it drives the ALU with run, element index and in-register slice offset.
- Captures the ALU lane result each cycle and merges it into a VLEN-wide destination image, honouring vl, tail-undisturbed and v0 masking.
- Hands the finished image to the register-file write port with a one-cycle write strobe.

Parameters:
- VLEN, 17'd128, vector register width in bits.
- LANE_WIDTH, 3'b011, log2 of lane width in bits. Must match the driven ALU instance.

Ports:
- clk  in  1  clock; all state on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  begin an operation. Sampled in IDLE only.
- kill  in  1  abort the current operation. Returns to IDLE with no write.
- vl  in  17  number of active elements. Sampled at start.
- vsew  in  3  element width code (0:8, 1:16, 2:32, 3:64 bits). Sampled at start.
- vm  in  1  1 = unmasked; 0 = use v0_mask. Sampled at start.
- v0_mask  in  VLEN  mask register, bit e enables element e. Sampled at start.
- vd_old  in  VLEN  current destination contents. Sampled at start.
- alu_instr_valid  in  1  ALU decode-valid for the current opcode.
- alu_vd  in  64  ALU lane result. Combinational, same cycle.
- alu_index  in  17  bit index in vd for alu_vd. Combinational, same cycle.
- alu_run  out  1  ALU run enable.
- alu_byte_i  out  17  current element number.
- alu_in_reg_offset  out  4  current slice within the element.
- alu_vsew  out  3  latched vsew.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse in DONE.
- vd_we  out  1  one-cycle write strobe, coincident with done.
- vd_out  out  VLEN  assembled destination image. Held until next accepted start.
- illegal  out  1  one-cycle pulse on a rejected start.

Behaviour:
- Reset (async, resetn=0): state IDLE. All outputs 0, including vd_out. Counters 0. Takes effect mid-operation with no write.
- Slices per element: S = 2^(vsew+3-LANE_WIDTH) if vsew+3 >= LANE_WIDTH, else 1.
- Write width per slice: W = min(2^(vsew+3), 2^LANE_WIDTH).
- States: IDLE, RUN, DONE.
- IDLE, start=1, illegal condition (vsew>3, or alu_instr_valid=0): pulse illegal next cycle, stay IDLE, vd_out unchanged.
- IDLE, start=1, legal:
  - Latch vl, vsew, vm, v0_mask.
  - Load vd_out <= vd_old.
  - Clear elem e=0 and offset o=0.
  - Go to RUN, or to DONE if vl==0.
- RUN:
  - Drive alu_run=1, alu_byte_i=e, alu_in_reg_offset=o.
  - If element enabled (vm=1 or v0_mask[e]=1), write vd_out[alu_index +: W] <= alu_vd[W-1:0] at the clock edge.
  - Masked elements still step through all S slices so ALU carry/compare state stays aligned. Writes are suppressed for them.
  - o increments each cycle. At o==S-1, o<=0 and e<=e+1.
  - At e==vl-1 and o==S-1, go to DONE.
- DONE: done=1, vd_we=1 for exactly one cycle, then IDLE.
- Latency: start accepted at edge t. RUN occupies vl*S cycles. done is high in cycle t+vl*S+1 (t+1 when vl==0).
- Tail: elements >= vl are never written and keep their vd_old value (tail-undisturbed).
- Masked elements keep their vd_old value (mask-undisturbed).
- vl > VLEN/2^(vsew+3): clamp to VLEN/2^(vsew+3).
- start while busy: ignored.
- kill in RUN or DONE: next state IDLE, no done/vd_we. vd_out keeps its partial contents (not to be consumed).
- kill and start in the same IDLE cycle: kill wins, start ignored.
- Outside RUN: alu_run=0, alu_byte_i=0, alu_in_reg_offset=0.

Test Plan:
- LANE_WIDTH=3, vsew=0, vl=4, vm=1, vadd vs2=i, vs1=1 → RUN 4 cycles, done at t+5, vd_out bytes 0..3 = 1,2,3,4, bytes 4..15 = vd_old.
- LANE_WIDTH=3, vsew=3, vl=2, vadd 0x00000000FFFFFFFF+1 → S=8, 16 RUN cycles, offsets 0..7 per element, element 0 = 0x0000000100000000 (carry across slices).
- vd_old=all 0xFF, vsew=0, vl=3, vand with 0 → bytes 0..2 = 0x00, bytes 3..15 = 0xFF.
- vm=0, v0_mask=16'b0101, vsew=0, vl=4, vor with 0xAA, vd_old=0 → bytes 0,2 = 0xAA+, bytes 1,3 = 0x00; still 4 RUN cycles.
- vl=0 → done/vd_we at t+1, vd_out = vd_old. vsew=3'b100 → illegal pulse, busy stays 0.
- Drop resetn in the 3rd RUN cycle → all outputs 0 immediately, no vd_we. kill in RUN → IDLE next cycle, no done.
